// File: rtl/ad7794_spi_master_if.sv
// Host-side request/response bundle for the AD7794 SPI master.
// The master modport is the requesting host; the slave modport is the SPI engine.
interface ad7794_spi_master_if;
  logic        start;
  logic [31:0] tx_data;
  logic [4:0]  nbits;
  logic        wait_rdy;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] rx_data;

  modport master (
    output start, tx_data, nbits, wait_rdy,
    input  busy, done, timeout, rx_data
  );

  modport slave (
    input  start, tx_data, nbits, wait_rdy,
    output busy, done, timeout, rx_data
  );
endinterface

// File: rtl/ad7794_spi_master.sv
// SPI mode-3 master for the AD7794 ADC: optional RDY wait, 1..32-bit full-duplex
// transfer, MSB first, fixed SCLK half-period of DIV clk cycles.
module ad7794_spi_master #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned TMO_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  ad7794_spi_master_if.slave         bus,
  output logic                       cs,
  output logic                       sclk,
  output logic                       dout,
  input  logic                       din
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_WAITRDY = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [8:0] HALF = 9'(DIV - 1);
  localparam logic [8:0] FULL = 9'(2 * DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [5:0]       bits_q, bits_d;
  logic [5:0]       nbits_q, nbits_d;
  logic             wait_q, wait_d;
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      rx_sh_q, rx_sh_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             din_s1_q, din_s2_q;

  // Left-justify the outgoing word so the first bit is always tx[31]; 0-nbits wraps to 32-N.
  logic [4:0]  shamt;
  logic [31:0] tx_load;
  assign shamt   = 5'd0 - bus.nbits;
  assign tx_load = bus.tx_data << shamt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    bits_d    = bits_q;
    nbits_d   = nbits_q;
    wait_d    = wait_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped; the host re-issues it next cycle.
        if (bus.start && !done_q) begin
          nbits_d   = {~|bus.nbits, bus.nbits};
          tx_d      = tx_load;
          wait_d    = bus.wait_rdy;
          rx_sh_d   = '0;
          cnt_d     = '0;
          tmo_d     = '0;
          bits_d    = '0;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          dout_d    = tx_load[31];
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (wait_q) begin
            state_d = S_WAITRDY;
          end else begin
            state_d = S_SHIFT;
            sclk_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_WAITRDY: begin
        if (!din_s2_q) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = '0;
        end else if (&tmo_q) begin
          state_d   = S_IDLE;
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          rx_data_d = '0;
          dout_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == HALF) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[30:0], din_s1_q};
        end else if (cnt_q == FULL) begin
          cnt_d = '0;
          if (bits_q == nbits_q - 6'd1) begin
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b0;
            bits_d = bits_q + 6'd1;
            tx_d   = {tx_q[30:0], 1'b0};
            dout_d = tx_q[30];
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == HALF) begin
          state_d   = S_IDLE;
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          dout_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      bits_q    <= '0;
      nbits_q   <= '0;
      wait_q    <= 1'b0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      din_s1_q  <= 1'b1;
      din_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bits_q    <= bits_d;
      nbits_q   <= nbits_d;
      wait_q    <= wait_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      din_s1_q  <= din;
      din_s2_q  <= din_s1_q;
    end
  end

  assign cs          = cs_q;
  assign sclk        = sclk_q;
  assign dout        = dout_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_ad7794_spi_master.sv
// Randomized bench for ad7794_spi_master: loopback and a simple ADC model on the
// serial side, transaction-level expectations computed from bit counts and masks.
module tb_ad7794_spi_master;
  localparam int unsigned DIV   = 2;
  localparam int unsigned TMO_W = 6;
  localparam int          LIMIT = 2000;

  logic clk = 1'b0;
  logic rst;
  logic cs, sclk, dout, din;

  ad7794_spi_master_if bus ();

  ad7794_spi_master #(.DIV(DIV), .TMO_W(TMO_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .cs   (cs),
    .sclk (sclk),
    .dout (dout),
    .din  (din)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // 0: loopback, 1: ADC model shifting out adc_word, 2: forced level
  int          din_mode  = 0;
  logic        din_force = 1'b1;
  logic        adc_bit   = 1'b0;
  logic [31:0] adc_word  = '0;
  int          adc_n     = 8;
  int          falls     = 0;
  logic [31:0] adc_rx    = '0;

  assign din = (din_mode == 0) ? dout : (din_mode == 1) ? adc_bit : din_force;

  // ADC side: presents the next bit on every falling SCLK, captures DIN on every rising SCLK
  always @(negedge sclk) begin
    if (!cs) begin
      int idx;
      falls = falls + 1;
      idx   = adc_n - falls;
      if (idx >= 0 && idx < 32) adc_bit = adc_word[idx];
    end
  end

  always @(posedge sclk) begin
    if (!cs) adc_rx = {adc_rx[30:0], dout};
  end

  int   cs_low = 0, rises = 0, dones = 0, dout_bad = 0;
  logic sclk_prev = 1'b1;

  always @(negedge clk) begin
    if (!cs) cs_low = cs_low + 1;
    if (sclk && !sclk_prev) rises = rises + 1;
    sclk_prev = sclk;
    if (bus.done) dones = dones + 1;
    if (cs && dout) dout_bad = dout_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nmask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Called at a negedge of clk; returns at a negedge with the bus idle.
  // ready_after < 0 with wr=1 means DIN never signals ready.
  task automatic run_txn(input logic [31:0] tx, input logic [4:0] nb, input bit wr,
                         input int mode, input logic [31:0] word,
                         input bit poke_busy, input bit poke_done, input int ready_after);
    int          n;
    int          i;
    bit          exp_tmo;
    logic [31:0] exp_rx;
    n       = (nb == 5'd0) ? 32 : int'(nb);
    exp_tmo = wr && (ready_after < 0);
    din_mode = (wr) ? 2 : mode;
    din_force = 1'b1;
    adc_word = word;
    adc_n    = n;
    falls    = 0;
    adc_bit  = 1'b0;
    adc_rx   = '0;
    cs_low = 0; rises = 0; dones = 0; dout_bad = 0;
    bus.tx_data  = tx;
    bus.nbits    = nb;
    bus.wait_rdy = wr;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.tx_data  = $urandom;
    bus.nbits    = 5'($urandom);
    check_eq("cs_after_start", {31'd0, cs}, 32'd0);
    check_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check_eq("first_dout", {31'd0, dout}, {31'd0, tx[n-1]});
    check_eq("timeout_cleared", {31'd0, bus.timeout}, 32'd0);
    i = 0;
    while (!bus.done && i < LIMIT) begin
      if (poke_busy && i == 5) begin
        bus.start = 1'b1;
        bus.tx_data = $urandom;
      end
      if (i == 6) bus.start = 1'b0;
      if (wr && ready_after >= 0 && i == int'(DIV) + ready_after) din_mode = 1;
      @(negedge clk);
      i = i + 1;
    end
    check_eq("done_seen", {31'd0, bus.done}, 32'd1);
    exp_rx = exp_tmo ? 32'd0 : ((din_mode == 0) ? (tx & nmask(n)) : (word & nmask(n)));
    check_eq("rx_data", bus.rx_data, exp_rx);
    check_eq("timeout_flag", {31'd0, bus.timeout}, {31'd0, exp_tmo});
    check_eq("cs_at_done", {31'd0, cs}, 32'd1);
    check_eq("busy_at_done", {31'd0, bus.busy}, 32'd0);
    if (poke_done) begin
      bus.start = 1'b1;
      bus.tx_data = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (poke_done) begin
      check_eq("start_at_done_ignored", {31'd0, cs}, 32'd1);
      @(negedge clk);
      check_eq("no_start_after_done", {31'd0, bus.busy}, 32'd0);
    end
    check_eq("rx_held", bus.rx_data, exp_rx);
    check_eq("done_count", dones, 32'd1);
    check_eq("sclk_rises", rises, exp_tmo ? 32'd0 : n);
    check_eq("dout_low_while_cs_high", dout_bad, 32'd0);
    if (exp_tmo)
      check_eq("cs_low_timeout", cs_low, DIV + (1 << TMO_W));
    else if (!wr)
      check_eq("cs_low_cycles", cs_low, 2 * DIV + 2 * DIV * n);
    if (!exp_tmo) check_eq("adc_received", adc_rx, tx & nmask(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    bus.start = 1'b0; bus.tx_data = '0; bus.nbits = '0; bus.wait_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_cs", {31'd0, cs}, 32'd1);
    check_eq("rst_sclk", {31'd0, sclk}, 32'd1);
    check_eq("rst_dout", {31'd0, dout}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    check_eq("rst_rx", bus.rx_data, 32'd0);
    rst = 1'b0;

    // Directed: start straight out of reset, full word, busy/done start pokes
    run_txn(32'h0000_00A5, 5'd8, 1'b0, 0, 32'd0, 1'b1, 1'b0, -1);
    run_txn(32'hDEAD_BEEF, 5'd0, 1'b0, 0, 32'd0, 1'b0, 1'b1, -1);
    run_txn(32'h0012_3456, 5'd24, 1'b0, 1, 32'h00AB_CDEF, 1'b0, 0, -1);
    run_txn(32'h0000_0001, 5'd1, 1'b0, 0, 32'd0, 1'b0, 1'b0, -1);

    // RDY wait: timeout, then a ready after 10 cycles
    run_txn(32'h0000_5A5A, 5'd16, 1'b1, 1, 32'h0000_C3C3, 1'b0, 1'b0, -1);
    run_txn(32'h0000_5A5A, 5'd16, 1'b1, 1, 32'h0000_C3C3, 1'b0, 1'b0, 10);

    // Reset in the middle of a transfer
    din_mode = 0;
    dones = 0; rises = 0;
    bus.tx_data = 32'h0000_00F0; bus.nbits = 5'd8; bus.wait_rdy = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    i = 0;
    while (rises < 5 && i < LIMIT) begin
      @(negedge clk);
      i = i + 1;
    end
    check_eq("reached_5th_edge", rises, 32'd5);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_cs", {31'd0, cs}, 32'd1);
    check_eq("async_rst_sclk", {31'd0, sclk}, 32'd1);
    check_eq("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("no_done_on_rst", dones, 32'd0);
    rst = 1'b0;
    run_txn(32'h0000_3C3C, 5'd14, 1'b0, 0, 32'd0, 1'b0, 1'b0, -1);

    // Random transfers
    for (int k = 0; k < 16; k++) begin
      logic [31:0] t, w;
      logic [4:0]  nb;
      t  = $urandom;
      w  = $urandom;
      nb = 5'($urandom);
      run_txn(t, nb, 1'b0, int'($urandom_range(0, 1)), w,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    for (int k = 0; k < 3; k++) begin
      run_txn($urandom, 5'($urandom), 1'b1, 1, $urandom, 1'b0, 1'b0,
              int'($urandom_range(2, 20)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ad7794_spi_master.md
AD7794_SPI_MASTER -- requirements
Module: ad7794_spi_master

Interface
REQ-001 SHALL have parameter DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter TMO_W, default 20: RDY-wait timeout is 2**TMO_W clk cycles.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle transaction request.
REQ-006 SHALL have port tx_data, input, 32: outgoing word, right-aligned.
REQ-007 SHALL have port nbits, input, 5: bits to transfer; 0 means 32.
REQ-008 SHALL have port wait_rdy, input, 1: wait for RDY (DOUT low) before clocking.
REQ-009 SHALL have port busy, output, 1: transaction in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port timeout, output, 1: last transaction aborted on RDY timeout.
REQ-012 SHALL have port rx_data, output, 32: received word, right-aligned.
REQ-013 SHALL have port cs, output, 1: ADC chip select, active low.
REQ-014 SHALL have port sclk, output, 1: ADC serial clock, idles high (SPI mode 3).
REQ-015 SHALL have port dout, output, 1: drives ADC DIN.
REQ-016 SHALL have port din, input, 1: from ADC DOUT/RDY; may be high-Z while cs high.

Function
REQ-017 SHALL implement states IDLE, SETUP, WAITRDY, SHIFT, HOLD.
REQ-018 SHALL register nbits, tx_data and wait_rdy on start in IDLE, and ignore start while busy=1.
REQ-019 SHALL, the cycle after an accepted start, drive cs=0, busy=1, and put dout = tx bit (N-1), where N is the effective bit count.
REQ-020 SHALL stay in SETUP for DIV cycles with sclk=1, then go to WAITRDY if wait_rdy=1, else SHIFT.
REQ-021 SHALL sample din in WAITRDY through a 2-flop synchronizer and leave for SHIFT on the first synchronized 0.
REQ-022 SHALL abort WAITRDY after 2**TMO_W cycles: cs=1, done=1, timeout=1, rx_data=0, no SCLK edges issued.
REQ-023 SHALL, in SHIFT, issue exactly N SCLK periods, each DIV cycles low then DIV cycles high.
REQ-024 SHALL, on each falling SCLK edge after the first, advance dout to the next lower tx bit; bits are sent MSB first.
REQ-025 SHALL sample registered din on each rising SCLK edge into an rx shifter, MSB first.
REQ-026 SHALL, after the Nth rising edge, hold cs=0 and sclk=1 for DIV cycles (HOLD), then set cs=1.
REQ-027 SHALL, in the same cycle that cs goes high, pulse done=1 for one cycle, clear busy, and update rx_data.
REQ-028 SHALL right-align rx_data with bits [31:N] zero, and hold it until the next done.
REQ-029 SHALL hold dout=0 whenever cs=1.
REQ-030 SHALL give a non-wait transaction cs-low duration of exactly 2*DIV + 2*DIV*N cycles.
REQ-031 SHALL clear timeout at the next accepted start.
REQ-032 SHALL accept a start presented in the cycle done is high only on the following cycle, which must be in IDLE.

Reset
REQ-033 SHALL, while rst=1, force state IDLE, cs=1, sclk=1, dout=0, busy=0, done=0, timeout=0, rx_data=0, counters 0.
REQ-034 SHALL, on rst asserted mid-transaction, abort immediately with no done pulse.
REQ-035 SHALL accept a start on the first rising clk edge after rst deasserts.

Verification
REQ-036 Loopback test (dout tied to din), DIV=2, nbits=8, tx=0xA5 -> cs low 36 cycles, 8 rising SCLK edges, done once, rx_data=0x000000A5.
REQ-037 Loopback test, nbits=0, tx=0xDEADBEEF -> 32 SCLK periods, rx_data=0xDEADBEEF, cs low 2*DIV*33 cycles.
REQ-038 With the AD7794 simulation model attached, nbits=24, tx=0x123456 -> model reports received word 0x00123456.
REQ-039 wait_rdy=1, TMO_W=6, din held 1 -> done and timeout after 64 WAITRDY cycles, 0 SCLK edges, rx_data=0; same test with din falling at cycle 10 -> normal transfer, timeout=0.
REQ-040 start during busy is ignored; rst at the 5th SCLK edge -> cs=1, sclk=1, busy=0 asynchronously, no done; the next start succeeds.
